booth_mac_acc: RTL
==================

Name: booth_mac_acc

Overview:
Frame-based signed multiply-accumulate back end. It sits directly downstream of the Booth/Dadda multiplier datapath and consumes the 20-bit two's-complement product (`result`) each beat. Products are summed into a wide saturating accumulator until a beat tagged last arrives. The frame total is then held on an output handshake until it is taken. `carry_out` from the tree is not used; the product is already a full signed value.

Parameters:
- PROD_W, 20, product width (signed two's complement)
- ACC_W, 24, accumulator and output width (signed); must be >= PROD_W
- CNT_W, 8, width of the beat counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; discards the current frame
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat
- in_prod  in  PROD_W  signed product from the multiplier tree
- in_last  in  1  beat is the final one of the frame
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts the result
- out_acc  out  ACC_W  signed frame sum (saturated)
- out_sat  out  1  sticky: saturation occurred in this frame
- out_cnt  out  CNT_W  beats in the frame, saturating at all-ones

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous, active-low.
- Reset values: state=IDLE; acc=0; sat=0; cnt=0; out_valid=0; out_acc=0; out_sat=0; out_cnt=0; in_ready=1.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_ready = (state != HOLD); it is registered-state based, with no combinational path from out_ready.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE: on a transfer, acc <= sext(in_prod), cnt <= 1, sat <= 0. Next state is HOLD if in_last, else ACCUM.
  - ACCUM: on a transfer, acc <= sat_add(acc, sext(in_prod)), sat |= overflow, cnt <= cnt+1 (saturating). Next state is HOLD if in_last. No transfer means hold state.
  - HOLD: out_valid=1. out_acc, out_sat and out_cnt reflect the final values and are stable while out_ready=0. On an output transfer, go to IDLE and clear acc, cnt and sat. The next frame's first beat can be accepted in the following cycle.
- Latency: out_valid rises in the cycle after the last beat is accepted. Throughput is 1 beat/cycle inside a frame. There is 1 bubble cycle between frames, in addition to the consumer wait.
- Arithmetic:
  - Sign-extend in_prod to ACC_W+1 bits and add.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that value. If it is below -2^(ACC_W-1), clamp to -2^(ACC_W-1).
  - Any clamp sets sat, which stays set until the frame is consumed.
  - After a clamp, later beats add to the clamped value; there is no wrap.
- Counter: cnt saturates at 2^CNT_W-1. It never wraps.
- Single-beat frame: IDLE with in_last=1 goes straight to HOLD with cnt=1 and acc=sext(in_prod).
- flush:
  - In any state, flush has top priority: next state=IDLE, acc/cnt/sat cleared, out_valid=0 next cycle.
  - A beat presented in the same cycle as flush is dropped, even though in_ready may be 1.
  - A pending HOLD result is discarded, even if out_ready=1 in the same cycle.
- Reset mid-frame: all state clears immediately and asynchronously; the partial frame is lost.
- Out-of-handshake inputs: in_prod and in_last are ignored when in_valid=0.

Decomposition:
- Package booth_mac_pkg holds:
  - the state typedef (enum logic [1:0] {IDLE, ACCUM, HOLD});
  - the localparams for PROD_W=20 (the tree output width) and the default ACC_W;
  - a function giving the signed max/min constants for a width.
- One sub-module, sat_add: a combinational signed saturating adder with parameter W and ports a, b, sum, ovf. It is instantiated once.
- The FSM, counter and output registers live in booth_mac_acc.

Test Plan:
1. Single beat: reset, then in_prod=20'hFFF38 (-200) with in_last=1 → one cycle later out_valid=1, out_acc=-200, out_cnt=1, out_sat=0; in_ready=0 until out_ready.
2. Mixed frame: beats +1000, -250, +7 (last) on consecutive cycles → out_acc=757, out_cnt=3, out_sat=0.
3. Positive saturation: 32 beats of +262144 (512*512), last on beat 32 → out_acc=8388607 (24'h7FFFFF), out_sat=1, out_cnt=32.
4. Negative saturation: 33 beats of -262144 → out_acc=-8388608, out_sat=1. Then the next frame (+5, last) → out_acc=5, out_sat=0.
5. Backpressure and flush:
   - Hold out_ready=0 for 10 cycles in HOLD → out_acc/out_sat/out_cnt stable, in_ready=0 throughout.
   - Then assert flush with out_ready=1 → no transfer counted, out_valid=0 next cycle, IDLE.
6. Async reset mid-frame: assert rst_n=0 between clock edges after 5 beats → outputs go to reset values without a clock edge. After release, a new frame (+3, last) gives out_acc=3, out_cnt=1.

Source files
------------

// File: rtl/booth_mac_pkg.sv
// booth_mac_pkg: shared types and constants for the Booth MAC accumulator back end.
//   state_e          - frame FSM states
//   TREE_PROD_W      - width of the multiplier tree product
//   DEF_ACC_W        - default accumulator width
//   sat_max/sat_min  - signed extreme values for a width, returned sign-extended to 64 bits
package booth_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned TREE_PROD_W = 20;
  localparam int unsigned DEF_ACC_W   = 24;

  // Largest signed value representable in w bits (w <= 64).
  function automatic logic [63:0] sat_max(input int unsigned w);
    sat_max = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative signed value in w bits, sign-extended to 64 bits.
  function automatic logic [63:0] sat_min(input int unsigned w);
    sat_min = ~sat_max(w);
  endfunction

endpackage

// File: rtl/booth_mac_acc_sat_add.sv
// sat_add: combinational signed saturating adder.
//   a, b - W-bit two's-complement operands
//   sum  - a + b clamped to the signed W-bit range
//   ovf  - high when the clamp was applied
module sat_add
  import booth_mac_pkg::*;
#(
  parameter int unsigned W = DEF_ACC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [63:0] MaxVal = sat_max(W);
  localparam logic [63:0] MinVal = sat_min(W);

  logic [W:0] wide;

  // One guard bit is enough: the sum of two W-bit values always fits in W+1 bits.
  assign wide = {a[W-1], a} + {b[W-1], b};

  always_comb begin
    sum = wide[W-1:0];
    ovf = 1'b0;
    if (wide[W] != wide[W-1]) begin
      ovf = 1'b1;
      sum = wide[W] ? MinVal[W-1:0] : MaxVal[W-1:0];
    end
  end

endmodule

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: frame-based signed saturating multiply-accumulate back end.
//   clk, rst_n           - clock, asynchronous active-low reset
//   flush                - synchronous abort of the current frame (top priority)
//   in_valid/in_ready    - product beat handshake; in_prod is the signed product, in_last ends frame
//   out_valid/out_ready  - frame result handshake
//   out_acc              - saturated frame sum
//   out_sat              - saturation occurred somewhere in the frame
//   out_cnt              - beats in the frame, saturating at all-ones
module booth_mac_acc
  import booth_mac_pkg::*;
#(
  parameter int unsigned PROD_W = TREE_PROD_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_cnt
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic               in_xfer;
  logic               out_xfer;

  assign prod_ext = ACC_W'($signed(in_prod));
  // A beat arriving with flush is dropped even though in_ready may be high.
  assign in_xfer  = in_valid & in_ready & ~flush;
  assign out_xfer = out_valid & out_ready;

  sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: if (in_xfer) state_d = in_last ? HOLD : ACCUM;
      HOLD:        if (out_xfer) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Outputs depend on registered state only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  // Accumulator, sticky saturation flag and beat counter.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          acc_d = prod_ext;
          sat_d = 1'b0;
          cnt_d = CNT_W'(1);
        end
      end
      ACCUM: begin
        if (in_xfer) begin
          acc_d = add_sum;
          sat_d = sat_q | add_ovf;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_xfer) begin
          acc_d = '0;
          sat_d = 1'b0;
          cnt_d = '0;
        end
      end
      default: begin
        acc_d = '0;
        sat_d = 1'b0;
        cnt_d = '0;
      end
    endcase
    if (flush) begin
      acc_d = '0;
      sat_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
      cnt_q <= cnt_d;
    end
  end

  // Frame registers double as the output registers; out_valid qualifies them.
  assign out_acc = acc_q;
  assign out_sat = sat_q;
  assign out_cnt = cnt_q;

endmodule
